// File: rtl/column_reduce.sv
// Streaming SUM/MIN/MAX/COUNT reducer over in_last-delimited groups; result held on a
// valid/ready port until taken. in_ready and out_valid come straight from the state register.
module column_reduce #(
  parameter int NUM_SIZE = 32,
  parameter int CNT_SIZE = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [1:0]                 op,
  input  logic                       in_valid,
  input  logic signed [NUM_SIZE-1:0] in_data,
  input  logic                       in_last,
  output logic                       in_ready,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic signed [NUM_SIZE-1:0] out_data,
  output logic [CNT_SIZE-1:0]        out_count,
  output logic                       out_overflow
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam logic [1:0] OP_SUM = 2'd0;
  localparam logic [1:0] OP_MIN = 2'd1;
  localparam logic [1:0] OP_MAX = 2'd2;
  localparam logic [1:0] OP_CNT = 2'd3;
  localparam logic [CNT_SIZE-1:0] CNT_MAX = '1;

  state_t                      state_q, state_d;
  logic [1:0]                  op_q, op_d;
  logic signed [NUM_SIZE-1:0]  acc_q, acc_d;
  logic [CNT_SIZE-1:0]         cnt_q, cnt_d;
  logic                        ovf_q, ovf_d;

  logic                        accept;
  logic signed [NUM_SIZE-1:0]  sum;
  logic                        sum_ovf;
  logic [CNT_SIZE-1:0]         cnt_inc;
  logic [NUM_SIZE-1:0]         cnt_ext;

  assign in_ready  = (state_q != HOLD);
  assign out_valid = (state_q == HOLD);
  assign accept    = in_valid && in_ready;

  // Two's-complement overflow: like-signed operands producing an opposite-signed sum.
  assign sum     = acc_q + in_data;
  assign sum_ovf = (acc_q[NUM_SIZE-1] == in_data[NUM_SIZE-1]) &&
                   (sum[NUM_SIZE-1] != acc_q[NUM_SIZE-1]);
  assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_SIZE'(1);

  generate
    if (NUM_SIZE > CNT_SIZE) begin : g_cnt_zext
      assign cnt_ext = {{(NUM_SIZE-CNT_SIZE){1'b0}}, cnt_q};
    end else if (NUM_SIZE == CNT_SIZE) begin : g_cnt_same
      assign cnt_ext = cnt_q;
    end else begin : g_cnt_trunc
      assign cnt_ext = cnt_q[NUM_SIZE-1:0];
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          op_d    = op;
          acc_d   = in_data;
          cnt_d   = CNT_SIZE'(1);
          ovf_d   = 1'b0;
          state_d = in_last ? HOLD : ACCUM;
        end
      end
      ACCUM: begin
        if (accept) begin
          case (op_q)
            OP_SUM: begin
              acc_d = sum;
              if (sum_ovf) ovf_d = 1'b1;
            end
            OP_MIN: if (in_data < acc_q) acc_d = in_data;
            OP_MAX: if (in_data > acc_q) acc_d = in_data;
            default: acc_d = acc_q;
          endcase
          cnt_d = cnt_inc;
          if (cnt_inc == CNT_MAX) ovf_d = 1'b1;
          if (in_last) state_d = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      op_q    <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  // Result fields are forced to zero whenever no result is being offered.
  always_comb begin
    out_data     = '0;
    out_count    = '0;
    out_overflow = 1'b0;
    if (state_q == HOLD) begin
      out_data     = (op_q == OP_CNT) ? $signed(cnt_ext) : acc_q;
      out_count    = cnt_q;
      out_overflow = ovf_q;
    end
  end

endmodule

// File: tb/tb_column_reduce.sv
// Directed plus randomized bench for column_reduce; results checked against a queue-based group model.
module tb_column_reduce;

  logic               clk = 1'b0;
  logic               reset;
  logic [1:0]         op;
  logic               in_valid;
  logic signed [31:0] in_data;
  logic               in_last;
  logic               in_ready, in_ready4;
  logic               out_valid, out_valid4;
  logic               out_ready;
  logic signed [31:0] out_data, out_data4;
  logic [15:0]        out_count;
  logic [3:0]         out_count4;
  logic               out_overflow, out_overflow4;

  int errors = 0;
  int checks = 0;

  logic [31:0] vals[$];

  localparam longint SMAX = 64'sd2147483647;
  localparam longint SMIN = -64'sd2147483648;

  column_reduce #(.NUM_SIZE(32), .CNT_SIZE(16)) dut (
    .clk(clk), .reset(reset), .op(op), .in_valid(in_valid), .in_data(in_data),
    .in_last(in_last), .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_count(out_count), .out_overflow(out_overflow)
  );

  column_reduce #(.NUM_SIZE(32), .CNT_SIZE(4)) dut4 (
    .clk(clk), .reset(reset), .op(op), .in_valid(in_valid), .in_data(in_data),
    .in_last(in_last), .in_ready(in_ready4), .out_valid(out_valid4), .out_ready(out_ready),
    .out_data(out_data4), .out_count(out_count4), .out_overflow(out_overflow4)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: fold the whole group with plain integer arithmetic.
  function automatic void model(input logic [1:0] o, input int cw,
                                output logic [31:0] d, output logic [31:0] c, output logic ov);
    int     acc;
    longint t;
    int     n;
    int     sat;
    n   = vals.size();
    sat = (1 << cw) - 1;
    acc = int'(vals[0]);
    ov  = 1'b0;
    for (int i = 1; i < n; i++) begin
      case (o)
        2'd0: begin
          t = longint'(acc) + longint'(int'(vals[i]));
          if (t > SMAX || t < SMIN) ov = 1'b1;
          acc = int'(t);
        end
        2'd1: if (int'(vals[i]) < acc) acc = int'(vals[i]);
        2'd2: if (int'(vals[i]) > acc) acc = int'(vals[i]);
        default: ;
      endcase
    end
    c = (n > sat) ? sat : n;
    if (n >= sat && n > 1) ov = 1'b1;
    d = (o == 2'd3) ? c : acc;
  endfunction

  // Presents every value in vals as one group; returns at the negedge after the last acceptance.
  task automatic drive_group(input logic [1:0] op_first, input logic [1:0] op_rest);
    int w;
    for (int i = 0; i < vals.size(); i++) begin
      @(negedge clk);
      op       = (i == 0) ? op_first : op_rest;
      in_valid = 1'b1;
      in_data  = vals[i];
      in_last  = (i == vals.size() - 1);
      w = 0;
      while (!in_ready && w < 20) begin
        @(negedge clk);
        w++;
      end
      if (w >= 20) chk("in_ready wait", {31'd0, in_ready}, 32'd1);
      @(posedge clk);
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = 32'hDEADBEEF;
  endtask

  task automatic check_group(input string tag, input logic [1:0] o);
    logic [31:0] d, c;
    logic        ov;
    model(o, 16, d, c, ov);
    chk({tag, " out_valid"}, {31'd0, out_valid}, 32'd1);
    chk({tag, " in_ready"}, {31'd0, in_ready}, 32'd0);
    chk({tag, " out_data"}, out_data, d);
    chk({tag, " out_count"}, {16'd0, out_count}, c);
    chk({tag, " out_overflow"}, {31'd0, out_overflow}, {31'd0, ov});
    if (out_ready) begin
      @(negedge clk);
      chk({tag, " valid drop"}, {31'd0, out_valid}, 32'd0);
      chk({tag, " ready back"}, {31'd0, in_ready}, 32'd1);
      chk({tag, " data idle"}, out_data, 32'd0);
    end
  endtask

  initial begin
    logic [1:0] ro, rr;
    int         n, k;
    logic [31:0] v;

    reset     = 1'b1;
    op        = 2'd0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst out_data", out_data, 32'd0);
    chk("rst out_count", {16'd0, out_count}, 32'd0);
    chk("rst out_overflow", {31'd0, out_overflow}, 32'd0);
    reset = 1'b0;

    vals = '{32'd5, -32'sd3, 32'd10, 32'd7};
    drive_group(2'd0, 2'd0);
    chk("sum4 literal", out_data, 32'd19);
    check_group("sum4", 2'd0);

    vals = '{32'd4, -32'sd8, 32'd9};
    drive_group(2'd1, 2'd2);
    chk("min literal", out_data, 32'hFFFF_FFF8);
    check_group("min", 2'd1);
    drive_group(2'd2, 2'd1);
    chk("max literal", out_data, 32'd9);
    check_group("max", 2'd2);

    vals = '{32'h7FFF_FFFF, 32'd1};
    drive_group(2'd0, 2'd0);
    chk("wrap literal", out_data, 32'h8000_0000);
    chk("wrap ovf literal", {31'd0, out_overflow}, 32'd1);
    check_group("wrap", 2'd0);
    vals = '{32'd1, 32'd1};
    drive_group(2'd0, 2'd0);
    check_group("after wrap", 2'd0);

    vals = '{32'd1, 32'd1, 32'd1};
    drive_group(2'd1, 2'd1);
    check_group("min tie", 2'd1);

    vals = '{32'd77};
    drive_group(2'd3, 2'd0);
    check_group("single count", 2'd3);

    // Back-pressure: the next group's first beat waits while the result is held.
    out_ready = 1'b0;
    vals = '{32'd11, 32'd22, 32'd33};
    drive_group(2'd3, 2'd0);
    check_group("bp count", 2'd3);
    vals = '{-32'sd50, 32'd20, 32'd7};
    fork
      drive_group(2'd0, 2'd1);
      begin
        for (int i = 0; i < 5; i++) begin
          @(negedge clk);
          chk("bp hold valid", {31'd0, out_valid}, 32'd1);
          chk("bp hold data", out_data, 32'd3);
          chk("bp hold in_ready", {31'd0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
      end
    join
    check_group("bp next", 2'd0);

    // Reset while accumulating discards the partial group.
    @(negedge clk);
    op = 2'd0; in_valid = 1'b1; in_data = 32'd100; in_last = 1'b0;
    @(negedge clk);
    in_data = 32'd200;
    @(negedge clk);
    in_valid = 1'b0;
    reset    = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("midrst in_ready", {31'd0, in_ready}, 32'd1);
    chk("midrst out_valid", {31'd0, out_valid}, 32'd0);
    vals = '{32'd1, 32'd2};
    drive_group(2'd0, 2'd0);
    chk("midrst literal", out_data, 32'd3);
    check_group("midrst", 2'd0);

    vals = {};
    for (int i = 0; i < 20; i++) vals.push_back($urandom);
    drive_group(2'd3, 2'd0);
    chk("sat4 count", {28'd0, out_count4}, 32'd15);
    chk("sat4 data", out_data4, 32'd15);
    chk("sat4 ovf", {31'd0, out_overflow4}, 32'd1);
    check_group("cnt20 wide", 2'd3);

    for (int g = 0; g < 40; g++) begin
      ro = 2'($urandom_range(0, 3));
      rr = 2'($urandom_range(0, 3));
      n  = $urandom_range(1, 8);
      vals = {};
      for (int i = 0; i < n; i++) begin
        case ($urandom_range(0, 3))
          0: v = 32'($urandom_range(0, 200)) - 32'd100;
          1: v = 32'h7FFF_FFF0 + 32'($urandom_range(0, 15));
          2: v = 32'h8000_0000 + 32'($urandom_range(0, 15));
          default: v = $urandom;
        endcase
        vals.push_back(v);
      end
      k = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0;
      out_ready = (k == 0);
      drive_group(ro, rr);
      if (k != 0) begin
        repeat (k) @(negedge clk);
        out_ready = 1'b1;
      end
      check_group("random", ro);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
